// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pulls words from a synchronous FIFO into a 3-entry skid buffer
// and presents them on a valid/ready stream. Statistics counters exist only under FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {IDLE, STREAM, STALL} state_t;

    logic [FIFO_WIDTH-1:0] mem [3];
    logic [1:0]            wr_idx, rd_idx, occ, occ_next;
    logic                  inflight, active, capture, pop;
    state_t                state;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Credit check uses registered state only, so m_ready never reaches fifo_rd_en.
    // 'active' keeps the read request low while reset is held and for the first edge after it.
    assign fifo_rd_en = active && !fifo_empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    assign capture    = inflight && !fifo_underflow;
    assign pop        = m_valid && m_ready;
    assign m_valid    = (state == STALL) || ((state == STREAM) && (occ != 2'd0));
    assign m_data     = mem[rd_idx];

    always_comb begin
        occ_next = occ;
        if (capture && !pop)
            occ_next = occ + 2'd1;
        else if (!capture && pop)
            occ_next = occ - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                mem[i] <= '0;
            wr_idx        <= 2'd0;
            rd_idx        <= 2'd0;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            active        <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            active   <= 1'b1;
            inflight <= fifo_rd_en;
            occ      <= occ_next;
            if (capture) begin
                mem[wr_idx] <= fifo_data_out;
                wr_idx      <= next_idx(wr_idx);
            end
            if (inflight && fifo_underflow)
                err_underflow <= 1'b1;
            if (pop)
                rd_idx <= next_idx(rd_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (occ_next == 2'd3)
            state <= STALL;
        else if ((occ_next != 2'd0) || fifo_rd_en)
            state <= STREAM;
        else
            state <= IDLE;
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] word_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop && (word_q != '1))
                word_q <= word_q + 1'b1;
            if (m_valid && !m_ready && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign word_cnt  = word_q;
    assign stall_cnt = stall_q;
`else
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule
